// File: rtl/ring_pkg.sv
// Package: ring_pkg
// Shared constants and helper functions for the ring-bus link pipes.
//  - Default payload widths for the level-1/level-2 rings and the off-chip link.
//  - Default pipeline depth and receive FIFO depth.
//  - cw_width(): width of a credit counter that must hold 0..depth inclusive.
//  - is_pow2(): configuration check used at elaboration.
package ring_pkg;

    localparam int RING_D_W        = 64;
    localparam int RING_A_W        = 32;
    localparam int RING_OFFCHIP_DW = 256;
    localparam int RING_PIPENUM    = 12;
    localparam int RING_FIFO_DEPTH = 32;

    // Credit counters hold the full FIFO depth, so they need one extra code point.
    function automatic int cw_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ring_lane.sv
// Module: ring_lane
// One credit-flow-controlled lane of the ring link.
//  Source side: credit counter gates s_ready; each accepted beat enters a
//  PIPENUM-deep forward pipe. Far end: receive FIFO, popped by the sink.
//  Every pop sends a credit back through a PIPENUM-deep return pipe.
// Ports:
//  clk, rst (sync, active high), ce (global clock enable)
//  s_valid/s_ready/s_data  : source beat interface
//  m_valid/m_ready/m_data  : sink interface (FIFO head)
//  credit_cnt              : current credit count
//  fifo_ovf                : sticky, a beat reached a full FIFO with no pop
module ring_lane
    import ring_pkg::*;
#(
    parameter int D_W        = RING_D_W,
    parameter int PIPENUM    = RING_PIPENUM,
    parameter int FIFO_DEPTH = RING_FIFO_DEPTH,
    localparam int CW        = cw_width(FIFO_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [D_W-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [D_W-1:0] m_data,
    output logic [CW-1:0]  credit_cnt,
    output logic           fifo_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (PIPENUM < 1 || FIFO_DEPTH < 2 * PIPENUM + 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_cfg
        $error("ring_lane: illegal PIPENUM/FIFO_DEPTH configuration");
    end

    // Stage registers exist purely to span physical distance; keep them as
    // discrete flops so tools do not retime, merge or pack them into shift LUTs.
    (* dont_touch = "true" *) logic [PIPENUM-1:0] fwd_v;
    (* dont_touch = "true" *) logic [D_W-1:0]     fwd_d [PIPENUM];
    (* dont_touch = "true" *) logic [PIPENUM-1:0] ret_v;

    logic [CW-1:0]  credit;
    logic [D_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           ovf;

    logic src_xfer, pop, push, full, wr_en, credit_in;

    assign s_ready    = ~rst & (credit != '0);
    assign src_xfer   = s_valid & s_ready & ce;
    assign m_valid    = ~rst & (count != '0);
    assign pop        = m_valid & m_ready & ce;
    assign push       = fwd_v[PIPENUM-1] & ce;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    // A pop frees the slot the incoming beat needs, so push+pop is legal even when full.
    assign wr_en      = push & (~full | pop);
    assign credit_in  = ret_v[PIPENUM-1];
    assign m_data     = mem[rd_ptr];
    assign credit_cnt = credit;
    assign fifo_ovf   = ovf;

    // Valid bits of both pipes: reset, shifted only when ce=1.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_v <= '0;
            ret_v <= '0;
        end else if (ce) begin
            fwd_v[0] <= src_xfer;
            ret_v[0] <= pop;
            for (int i = 1; i < PIPENUM; i++) begin
                fwd_v[i] <= fwd_v[i-1];
                ret_v[i] <= ret_v[i-1];
            end
        end
    end

    // Payload stages load only behind a valid beat.
    // NOTE: data path registers and FIFO storage carry no reset; only valids/pointers need one.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (src_xfer) fwd_d[0] <= s_data;
            for (int i = 1; i < PIPENUM; i++) begin
                if (fwd_v[i-1]) fwd_d[i] <= fwd_d[i-1];
            end
        end
    end

    // Credit counter: spend on source transfer, refund on return-pipe arrival.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CW'(FIFO_DEPTH);
        end else if (ce) begin
            case ({src_xfer, credit_in})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   credit <= credit + CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ce && wr_en) mem[wr_ptr] <= fwd_d[PIPENUM-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (ce) begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/ring_link_pipe.sv
// Module: ring_link_pipe
// Multi-lane credit-flow-controlled pipelined link for the ring buses.
// Generates NCH independent ring_lane instances and slices the flat buses.
// Ports:
//  clk, rst (sync, active high), ce (global clock enable)
//  s_valid[NCH], s_ready[NCH], s_data[NCH*D_W]  : source side, lane k = [k*D_W +: D_W]
//  m_valid[NCH], m_ready[NCH], m_data[NCH*D_W]  : sink side
//  credit_cnt[NCH*CW]                           : per-lane credit counters
//  fifo_ovf[NCH]                                : per-lane sticky overflow flags
module ring_link_pipe
    import ring_pkg::*;
#(
    parameter int D_W        = RING_D_W,
    parameter int NCH        = 4,
    parameter int PIPENUM    = RING_PIPENUM,
    parameter int FIFO_DEPTH = RING_FIFO_DEPTH,
    localparam int CW        = cw_width(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [NCH-1:0]     s_valid,
    output logic [NCH-1:0]     s_ready,
    input  logic [NCH*D_W-1:0] s_data,
    output logic [NCH-1:0]     m_valid,
    input  logic [NCH-1:0]     m_ready,
    output logic [NCH*D_W-1:0] m_data,
    output logic [NCH*CW-1:0]  credit_cnt,
    output logic [NCH-1:0]     fifo_ovf
);

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        ring_lane #(
            .D_W        (D_W),
            .PIPENUM    (PIPENUM),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .ce         (ce),
            .s_valid    (s_valid[k]),
            .s_ready    (s_ready[k]),
            .s_data     (s_data[k*D_W +: D_W]),
            .m_valid    (m_valid[k]),
            .m_ready    (m_ready[k]),
            .m_data     (m_data[k*D_W +: D_W]),
            .credit_cnt (credit_cnt[k*CW +: CW]),
            .fifo_ovf   (fifo_ovf[k])
        );
    end

endmodule
